// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
// Holds the PC select codes, the misalignment cause code and the FSM state encoding.
package pc_unit_pkg;

    // Next-PC source selection; codes 101-111 fall back to sequential flow.
    localparam logic [2:0] PC_SEL_SEQ    = 3'b000;
    localparam logic [2:0] PC_SEL_BRANCH = 3'b001;
    localparam logic [2:0] PC_SEL_JAL    = 3'b010;
    localparam logic [2:0] PC_SEL_JALR   = 3'b011;
    localparam logic [2:0] PC_SEL_MRET   = 3'b100;

    // Cause code recorded for a misaligned control-flow target.
    localparam int unsigned CAUSE_MISALIGNED = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } pc_state_e;

    // A target is misaligned when either of its two low bits is set.
    function automatic logic lsb_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_unit_next_mux.sv
// Combinational next-PC target generator with misalignment detection.
// Ports: pc_sel_i, comparator_i, imm_i, alu_i, pc_i, epc_i -> target_o, misaligned_o.
module pc_unit_next_mux
    import pc_unit_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]        pc_sel_i,
    input  logic              comparator_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [DWIDTH-1:0] alu_i,
    input  logic [DWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] epc_i,
    output logic [DWIDTH-1:0] target_o,
    output logic              misaligned_o
);

    localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

    logic [DWIDTH-1:0] seq_pc;
    logic [DWIDTH-1:0] rel_pc;
    logic [DWIDTH-1:0] jalr_pc;
    logic              chk_align;

    assign seq_pc  = pc_i + PC_STEP;
    assign rel_pc  = pc_i + imm_i;
    // JALR drops bit 0 of the ALU sum, so only bit 1 can still misalign it.
    assign jalr_pc = {alu_i[DWIDTH-1:1], 1'b0};

    always_comb begin
        target_o  = seq_pc;
        chk_align = 1'b0;
        case (pc_sel_i)
            PC_SEL_BRANCH: begin
                if (comparator_i) begin
                    target_o  = rel_pc;
                    chk_align = 1'b1;
                end
            end
            PC_SEL_JAL: begin
                target_o  = rel_pc;
                chk_align = 1'b1;
            end
            PC_SEL_JALR: begin
                target_o  = jalr_pc;
                chk_align = 1'b1;
            end
            // EPC always holds a committed, aligned PC.
            PC_SEL_MRET: begin
                target_o = epc_i;
            end
            default: begin
                target_o = seq_pc;
            end
        endcase
    end

    assign misaligned_o = chk_align && lsb_misaligned(target_o[1:0]);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection and trap entry.
// Ports: clk/reset, pc_en, pc_select, comparator, immgen_in, alu_in, trap_req/trap_cause_in
//        -> pc_value, link_out, epc, trap_cause, bad_addr, trap_valid, busy.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DWIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              CAUSE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_en,
    input  logic [2:0]         pc_select,
    input  logic               comparator,
    input  logic [DWIDTH-1:0]  immgen_in,
    input  logic [DWIDTH-1:0]  alu_in,
    input  logic               trap_req,
    input  logic [CAUSE_W-1:0] trap_cause_in,
    output logic [DWIDTH-1:0]  pc_value,
    output logic [DWIDTH-1:0]  link_out,
    output logic [DWIDTH-1:0]  epc,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic [DWIDTH-1:0]  bad_addr,
    output logic               trap_valid,
    output logic               busy
);

    localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

    pc_state_e          state_q, state_d;
    logic [DWIDTH-1:0]  pc_q, pc_d;
    logic [DWIDTH-1:0]  epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [DWIDTH-1:0]  bad_q, bad_d;
    logic               tvalid_q, tvalid_d;

    logic [DWIDTH-1:0]  target;
    logic               misaligned;

    pc_unit_next_mux #(
        .DWIDTH(DWIDTH)
    ) u_next_mux (
        .pc_sel_i     (pc_select),
        .comparator_i (comparator),
        .imm_i        (immgen_in),
        .alu_i        (alu_in),
        .pc_i         (pc_q),
        .epc_i        (epc_q),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VECTOR;
            epc_q    <= '0;
            cause_q  <= '0;
            bad_q    <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            bad_q    <= bad_d;
            tvalid_q <= tvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        bad_d    = bad_q;
        tvalid_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (pc_en) begin
                    // External traps outrank a misaligned target; PC holds in both.
                    if (trap_req) begin
                        epc_d   = pc_q;
                        cause_d = trap_cause_in;
                        bad_d   = '0;
                        state_d = ST_TRAP;
                    end else if (misaligned) begin
                        epc_d   = pc_q;
                        cause_d = CAUSE_W'(CAUSE_MISALIGNED);
                        bad_d   = target;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            ST_TRAP: begin
                // Redirect happens even while stalled.
                pc_d     = TRAP_VECTOR;
                tvalid_d = 1'b1;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc_value   = pc_q;
    assign link_out   = pc_q + PC_STEP;
    assign epc        = epc_q;
    assign trap_cause = cause_q;
    assign bad_addr   = bad_q;
    assign trap_valid = tvalid_q;
    assign busy       = (state_q == ST_TRAP);

endmodule
